bit_seq_scheduler: RTL and testbench

Upstream feeder for the clocked 8-to-3 priority encoder in the bit-serial PE datapath. Accepts one unsigned operand per handshake and emits its set bits one at a time, MSB-first, as one-hot masks. Each mask is directly consumable as the encoder's bitmask input. All-zero operands emit a single zero beat, so the encoder's is_zero path is exercised.

---
 rtl/bit_seq_scheduler.sv | 143 ++++++++++++++
 tb/tb_bit_seq_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_seq_scheduler.sv
// bit_seq_scheduler
//   Feeds the clocked 8-to-3 priority encoder of the bit-serial PE datapath.
//   It takes one unsigned operand per valid/ready handshake. It then emits the
//   operand's set bits one at a time, MSB first, as one-hot masks. An all-zero
//   operand produces a single zero beat (out_onehot=0, out_zero=1), so the
//   encoder's is_zero path is exercised.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   in_data       operand magnitude            (DATA_WIDTH)
//   in_valid      operand valid
//   in_ready      operand accepted this cycle when in_valid is also high
//   out_onehot    one-hot of the current leading one; 0 on a zero beat
//   out_valid     out_onehot / out_last / out_zero are valid
//   out_ready     downstream accepts the beat
//   out_last      final beat for the current operand
//   out_zero      operand was all-zero
//   beat_cnt      beats already accepted for the current operand
//   out_trunc     (only with BIT_SCHED_TRUNC_EN) last beat dropped lower bits
//
// Optional feature
//   BIT_SCHED_TRUNC_EN: caps each operand at MAX_BITS beats. Any remaining
//   lower set bits are dropped, and out_trunc flags the capped last beat.
module bit_seq_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BITS   = 4,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_onehot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_zero,
  output logic [CNT_W-1:0]      beat_cnt
`ifdef BIT_SCHED_TRUNC_EN
  ,output logic                 out_trunc
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DATA_WIDTH-1:0] ONE     = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] res, res_n;
  logic                  zero, zero_n;
  logic [CNT_W-1:0]      cnt_n;

  logic [DATA_WIDTH-1:0] lead;
  logic                  single;
  logic                  cap_hit;
  logic                  accept;
  logic                  beat_fire;

  // Leading one of the residual. The scan runs upward, so the last hit wins
  // and the result is the MSB.
  always_comb begin
    lead = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (res[i]) begin
        lead    = '0;
        lead[i] = 1'b1;
      end
  end

  assign single = (res != '0) && ((res & (res - ONE)) == '0);

`ifdef BIT_SCHED_TRUNC_EN
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(MAX_BITS - 1);
  assign cap_hit = (beat_cnt == CAP_CNT);
`else
  assign cap_hit = 1'b0;
`endif

  // Outputs come only from registered state. They therefore hold steady
  // under backpressure. in_ready also opens on the last beat's handshake,
  // so the next operand lands with no bubble.
  always_comb begin
    out_valid  = 1'b0;
    out_onehot = '0;
    out_last   = 1'b0;
    out_zero   = 1'b0;
`ifdef BIT_SCHED_TRUNC_EN
    out_trunc  = 1'b0;
`endif
    state_n    = state;
    res_n      = res;
    zero_n     = zero;
    cnt_n      = beat_cnt;

    if (state == RUN) begin
      out_valid  = 1'b1;
      out_onehot = zero ? '0 : lead;
      out_last   = zero | single | cap_hit;
      out_zero   = zero;
`ifdef BIT_SCHED_TRUNC_EN
      out_trunc  = cap_hit & ~zero & ~single;
`endif
    end

    beat_fire = out_valid & out_ready;
    in_ready  = ~reset & ((state == IDLE) | (beat_fire & out_last));
    accept    = in_valid & in_ready;

    if (accept) begin
      state_n = RUN;
      res_n   = in_data;
      zero_n  = (in_data == '0);
      cnt_n   = '0;
    end else if (beat_fire) begin
      if (out_last) begin
        state_n = IDLE;
        res_n   = '0;
        zero_n  = 1'b0;
        cnt_n   = '0;
      end else begin
        res_n = res & ~lead;
        cnt_n = beat_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      res      <= '0;
      zero     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      res      <= res_n;
      zero     <= zero_n;
      beat_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bit_seq_scheduler.sv
module tb_bit_seq_scheduler;
  localparam int DW    = 8;
  localparam int MAXB  = 4;
  localparam int CNT_W = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_onehot;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          out_zero;
  logic [CNT_W-1:0] beat_cnt;
`ifdef BIT_SCHED_TRUNC_EN
  logic          out_trunc;
`endif

  bit_seq_scheduler #(.DATA_WIDTH(DW), .MAX_BITS(MAXB)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_zero(out_zero),
    .beat_cnt(beat_cnt)
`ifdef BIT_SCHED_TRUNC_EN
    , .out_trunc(out_trunc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] onehot;
    logic          last;
    logic          zero;
    int            cnt;
    logic          trunc;
  } beat_t;
  typedef logic [DW-1:0] bq_t[$];

  beat_t q[$];     // expected beats still to be delivered
  beat_t seen[$];  // beats actually handed off, recorded from the DUT
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the operand's set bits, scanned from the MSB down and capped by
  // the beat budget. Zero gives one zero beat.
  function automatic void push_operand(input logic [DW-1:0] d);
    int limit, pc, nb, n;
    beat_t b;
`ifdef BIT_SCHED_TRUNC_EN
    limit = MAXB;
`else
    limit = DW;
`endif
    pc = $countones(d);
    if (pc == 0) begin
      b.onehot = '0; b.last = 1'b1; b.zero = 1'b1; b.cnt = 0; b.trunc = 1'b0;
      q.push_back(b);
      return;
    end
    nb = (pc > limit) ? limit : pc;
    n  = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (d[i] && n < nb) begin
        b.onehot = '0;
        b.onehot[i] = 1'b1;
        b.last  = (n == nb - 1);
        b.zero  = 1'b0;
        b.cnt   = n;
        b.trunc = (n == nb - 1) && (pc > nb);
        q.push_back(b);
        n++;
      end
    end
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic  exp_rdy;
    beat_t o;
    if (reset) begin
      chk("in_ready_in_reset", in_ready, 1'b0);
      q.delete();
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_onehot", out_onehot, q[0].onehot);
        chk("out_last", out_last, q[0].last);
        chk("out_zero", out_zero, q[0].zero);
        chk("beat_cnt", beat_cnt, q[0].cnt);
`ifdef BIT_SCHED_TRUNC_EN
        chk("out_trunc", out_trunc, q[0].trunc);
`endif
        if (out_ready) begin
          o.onehot = out_onehot; o.last = out_last; o.zero = out_zero;
          o.cnt = int'(beat_cnt); o.trunc = 1'b0;
          seen.push_back(o);
          void'(q.pop_front());
        end
      end else begin
        chk("idle_onehot", out_onehot, '0);
        chk("idle_last", out_last, 1'b0);
        chk("idle_zero", out_zero, 1'b0);
      end
      if (in_valid && exp_rdy) push_operand(in_data);
    end
  end

  // Hold the operand until accepted, then drop in_valid after the edge.
  task automatic send(input logic [DW-1:0] d);
    logic acc;
    int   g;
    in_data  = d;
    in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 100);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seen(input string nm, input bq_t e);
    chk({nm, "_count"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++)
      chk(nm, seen[i].onehot, e[i]);
  endtask

  initial begin
    bq_t e;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_beat_cnt", beat_cnt, 0);
    @(posedge clk); #1;

    // MSB-first bit walk
    seen.delete();
    send(8'b1010_0110);
    drain();
    e = '{8'h80, 8'h20, 8'h04, 8'h02};
    chk_seen("a6_beats", e);
    if (seen.size() == 4) begin
      chk("a6_last", seen[3].last, 1'b1);
      chk("a6_mid_last", seen[2].last, 1'b0);
      chk("a6_cnt3", seen[3].cnt, 3);
    end

    // Zero operand, then 01 accepted on the zero beat
    seen.delete();
    send(8'h00);
    send(8'h01);
    drain();
    e = '{8'h00, 8'h01};
    chk_seen("zero_beats", e);
    if (seen.size() == 2) begin
      chk("zero_flag", seen[0].zero, 1'b1);
      chk("zero_last", seen[0].last, 1'b1);
      chk("one_zero", seen[1].zero, 1'b0);
    end

    // Back-to-back operands
    seen.delete();
    send(8'h81);
    send(8'h40);
    drain();
    e = '{8'h80, 8'h01, 8'h40};
    chk_seen("b2b_beats", e);

    // Backpressure on the first beat
    seen.delete();
    out_ready = 1'b0;
    send(8'hC0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_onehot", out_onehot, 8'h80);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_cnt", beat_cnt, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    e = '{8'h80, 8'h40};
    chk_seen("bp_beats", e);

    // Reset mid-operand
    seen.delete();
    send(8'hFF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_ready", in_ready, 1'b1);
    chk("postrst_valid", out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    e = '{8'h80};
    chk_seen("midrst_beats", e);

    // Full operand: capped when truncation is enabled
    seen.delete();
    send(8'hFF);
    drain();
`ifdef BIT_SCHED_TRUNC_EN
    e = '{8'h80, 8'h40, 8'h20, 8'h10};
`else
    e = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
`endif
    chk_seen("ff_beats", e);
    seen.delete();
    send(8'h11);
    drain();
    e = '{8'h10, 8'h01};
    chk_seen("h11_beats", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
